hash_readout: RTL and testbench

//  Read-side counterpart of the message loader: drains the 256-bit SHA-256 digest produced by the

---
 rtl/mining_pkg.sv | 13 +
 rtl/lzc256.sv | 39 +++
 rtl/hash_readout.sv | 90 +++++++++
 tb/tb_hash_readout.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// rtl/mining_pkg.sv - shared widths and state encoding for the digest readout path
package mining_pkg;
    localparam int HASH_W = 256;
    localparam int WORD_W = 32;
    localparam int WORDS  = HASH_W / WORD_W;
    localparam int IDX_W  = 3;
    localparam int LZ_W   = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;
endpackage

// File: rtl/lzc256.sv
// rtl/lzc256.sv - combinational leading-zero counter for a 256-bit digest
module lzc256
    import mining_pkg::*;
(
    input  logic [HASH_W-1:0] hash,
    output logic [LZ_W-1:0]   lz_count
);

    function automatic logic [2:0] lz4(input logic [3:0] n);
        casez (n)
            4'b1???: lz4 = 3'd0;
            4'b01??: lz4 = 3'd1;
            4'b001?: lz4 = 3'd2;
            4'b0001: lz4 = 3'd3;
            default: lz4 = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lz8(input logic [7:0] v);
        if (v[7:4] != 4'd0) lz8 = {1'b0, lz4(v[7:4])};
        else                lz8 = 4'd4 + {1'b0, lz4(v[3:0])};
    endfunction

    function automatic logic [4:0] lz16(input logic [15:0] v);
        if (v[15:8] != 8'd0) lz16 = {1'b0, lz8(v[15:8])};
        else                 lz16 = 5'd8 + {1'b0, lz8(v[7:0])};
    endfunction

    // Scan from the least significant group up so the most significant non-zero group wins.
    always_comb begin
        lz_count = LZ_W'(HASH_W);
        for (int g = HASH_W / 16 - 1; g >= 0; g--) begin
            if (hash[HASH_W-1-16*g -: 16] != 16'd0) begin
                lz_count = LZ_W'(16 * g) + LZ_W'(lz16(hash[HASH_W-1-16*g -: 16]));
            end
        end
    end

endmodule

// File: rtl/hash_readout.sv
// rtl/hash_readout.sv - captures a SHA-256 digest and streams it out MSW-first with a difficulty score
module hash_readout
    import mining_pkg::*;
#(
    parameter int DIFFICULTY = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hash_done,
    input  logic [HASH_W-1:0] HASH,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic [IDX_W-1:0]  word_index,
    output logic              word_last,
    output logic              busy,
    output logic [LZ_W-1:0]   lz_count,
    output logic              meets_target,
    output logic              overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [LZ_W-1:0]  DIFF     = LZ_W'(DIFFICULTY);

    state_e             state_q, state_d;
    logic [HASH_W-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LZ_W-1:0]    lz_q, lz_d;
    logic               meets_q, meets_d;
    logic               overrun_q, overrun_d;
    logic [LZ_W-1:0]    lz_new;
    logic               xfer, final_xfer, capture;

    lzc256 u_lzc (
        .hash     (HASH),
        .lz_count (lz_new)
    );

    // A digest arriving on the final transfer is taken back-to-back; any other one in SEND is lost.
    always_comb begin
        xfer       = (state_q == ST_SEND) && word_ready;
        final_xfer = xfer && (idx_q == LAST_IDX);
        capture    = hash_done && ((state_q == ST_IDLE) || final_xfer);
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        lz_d       = lz_q;
        meets_d    = meets_q;
        overrun_d  = overrun_q | (hash_done && !capture);
        if (capture) begin
            state_d  = ST_SEND;
            shadow_d = HASH;
            idx_d    = '0;
            lz_d     = lz_new;
            meets_d  = (lz_new >= DIFF);
        end else if (final_xfer) begin
            state_d = ST_IDLE;
        end else if (xfer) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            lz_q      <= '0;
            meets_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            lz_q      <= lz_d;
            meets_q   <= meets_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_valid   = (state_q == ST_SEND);
    assign busy         = word_valid;
    assign word_index   = idx_q;
    assign word_last    = word_valid && (idx_q == LAST_IDX);
    assign word_out     = shadow_q[HASH_W-1-WORD_W*int'(idx_q) -: WORD_W];
    assign lz_count     = lz_q;
    assign meets_target = meets_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_hash_readout.sv
// tb/tb_hash_readout.sv - directed self-checking bench for hash_readout
module tb_hash_readout;

    logic         clock;
    logic         reset;
    logic         hash_done;
    logic [255:0] HASH;
    logic         word_ready;
    logic [31:0]  word_out;
    logic         word_valid;
    logic [2:0]   word_index;
    logic         word_last;
    logic         busy;
    logic [8:0]   lz_count;
    logic         meets_target;
    logic         overrun;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [255:0] D1 = 256'h00000000_0000FFFF_12345678_9ABCDEF0_DEADBEEF_CAFEBABE_0F0F0F0F_00000001;
    localparam logic [255:0] D2 = 256'h00012345_6789ABCD_EF012345_6789ABCD_11111111_22222222_33333333_44444444;
    localparam logic [255:0] DZ = 256'h0;
    localparam logic [255:0] DM = {1'b1, 255'h0};

    hash_readout #(.DIFFICULTY(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .hash_done    (hash_done),
        .HASH         (HASH),
        .word_ready   (word_ready),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_index   (word_index),
        .word_last    (word_last),
        .busy         (busy),
        .lz_count     (lz_count),
        .meets_target (meets_target),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_total++;
        if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        else n_pass++;
    endtask

    task automatic capture(input logic [255:0] d);
        @(posedge clock); #1;
        HASH = d;
        hash_done = 1'b1;
        @(posedge clock); #1;
        hash_done = 1'b0;
    endtask

    task automatic run_stream(input logic [255:0] d, input int inj, input logic [255:0] d2);
        logic [31:0] w;
        word_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            w = d[255-32*k -: 32];
            chk("valid", word_valid, 1);
            chk("busy", busy, 1);
            chk("index", word_index, k);
            chk("word", word_out, w);
            chk("last", word_last, k == 7);
            if (k == inj) begin
                HASH = d2;
                hash_done = 1'b1;
            end
            @(posedge clock); #1;
            hash_done = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        chk("rst_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_word", word_out, 0);
        chk("rst_lz", lz_count, 0);
        chk("rst_meets", meets_target, 0);
        chk("rst_last", word_last, 0);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int c;
        hash_done  = 1'b0;
        HASH       = '0;
        word_ready = 1'b0;
        reset      = 1'b0;
        @(posedge clock); #1;
        do_reset();

        // 1: full stream, ready held high
        capture(D1);
        run_stream(D1, -1, '0);
        @(negedge clock);
        chk("t1_idle_valid", word_valid, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_lz", lz_count, 48);
        chk("t1_meets", meets_target, 1);
        chk("t1_overrun", overrun, 0);

        // 2: ready toggling 1,0,0,...
        @(posedge clock); #1;
        word_ready = 1'b0;
        capture(D1);
        n = 0;
        c = 0;
        while (n < 8 && c < 60) begin
            word_ready = (c % 3 == 0);
            @(negedge clock);
            chk("t2_valid", word_valid, 1);
            chk("t2_index", word_index, n);
            chk("t2_word", word_out, D1[255-32*n -: 32]);
            if (word_ready) n++;
            @(posedge clock); #1;
            c++;
        end
        chk("t2_transfers", n, 8);
        @(negedge clock);
        chk("t2_busy_after", busy, 0);

        // 3: second digest mid-stream is dropped
        @(posedge clock); #1;
        capture(D1);
        run_stream(D1, 3, D2);
        @(negedge clock);
        chk("t3_overrun", overrun, 1);
        chk("t3_no_second", word_valid, 0);
        chk("t3_lz_kept", lz_count, 48);

        // 4: digest on the final transfer restarts with no gap
        @(posedge clock); #1;
        do_reset();
        capture(D1);
        run_stream(D1, 7, D2);
        run_stream(D2, -1, '0);
        @(negedge clock);
        chk("t4_overrun", overrun, 0);
        chk("t4_lz", lz_count, 15);
        chk("t4_meets", meets_target, 0);
        chk("t4_idle", word_valid, 0);

        // 5: all-zero and MSB-set digests
        @(posedge clock); #1;
        word_ready = 1'b0;
        capture(DZ);
        @(negedge clock);
        chk("t5_zero_lz", lz_count, 256);
        chk("t5_zero_meets", meets_target, 1);
        @(posedge clock); #1;
        run_stream(DZ, -1, '0);
        word_ready = 1'b0;
        capture(DM);
        @(negedge clock);
        chk("t5_msb_lz", lz_count, 0);
        chk("t5_msb_meets", meets_target, 0);
        @(posedge clock); #1;
        run_stream(DM, -1, '0);

        // 6: reset mid-stream
        word_ready = 1'b1;
        capture(D1);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                HASH = D2;
                hash_done = 1'b1;
            end
            @(posedge clock); #1;
            hash_done = 1'b0;
        end
        @(negedge clock);
        chk("t6_index5", word_index, 5);
        chk("t6_overrun_set", overrun, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid_async", word_valid, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_overrun_async", overrun, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        capture(D2);
        run_stream(D2, -1, '0);
        @(negedge clock);
        chk("t6_end_idle", word_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
